// File: rtl/atm_session_controller.sv
// ATM session controller: multi-account balances and PINs, PIN lockout, per-session
// withdrawal limit, and a shared history ring streamed out as a mini-statement.
module atm_session_controller #(
  parameter int NUM_ACCOUNTS = 4,
  parameter int ACCT_W       = $clog2(NUM_ACCOUNTS),
  parameter int BAL_W        = 16,
  parameter int AMT_W        = 8,
  parameter int PIN_W        = 4,
  parameter int DEFAULT_PIN  = 4,
  parameter int INIT_BALANCE = 128,
  parameter int MAX_ATTEMPTS = 3,
  parameter int LOCK_CYCLES  = 24,
  parameter int WD_LIMIT     = 100,
  parameter int HIST_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              card_valid,
  input  logic [ACCT_W-1:0] card_id,
  input  logic              pin_valid,
  input  logic [PIN_W-1:0]  pin_in,
  input  logic              op_valid,
  input  logic [2:0]        op_code,
  input  logic [AMT_W-1:0]  amount,
  output logic              ready,
  output logic              resp_valid,
  output logic [2:0]        status,
  output logic [BAL_W-1:0]  balance_out,
  output logic              locked,
  output logic              stmt_valid,
  output logic [AMT_W:0]    stmt_data,
  output logic              stmt_done
);
  localparam int HIST_W = $clog2(HIST_DEPTH);
  localparam int ATT_W  = $clog2(MAX_ATTEMPTS + 1);
  localparam int TMR_W  = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_PIN, S_MENU, S_STMT, S_LOCKED} state_t;
  typedef enum logic [2:0] {
    ST_OK = 3'd0, ST_BAD_PIN = 3'd1, ST_NO_FUNDS = 3'd2, ST_LIMIT = 3'd3,
    ST_OVERFLOW = 3'd4, ST_LOCKED = 3'd5, ST_BAD_OP = 3'd6
  } status_t;

  state_t            r_state, w_next;
  logic [ACCT_W-1:0] r_acct, w_acct;
  logic [ATT_W-1:0]  r_att, w_att;
  logic [TMR_W-1:0]  r_tmr, w_tmr;
  logic [BAL_W-1:0]  r_wd, w_wd;
  logic [BAL_W-1:0]  r_bal [NUM_ACCOUNTS];
  logic [PIN_W-1:0]  r_pin [NUM_ACCOUNTS];
  logic [ACCT_W-1:0] r_h_acct [HIST_DEPTH];
  logic              r_h_type [HIST_DEPTH];
  logic [AMT_W-1:0]  r_h_amt  [HIST_DEPTH];
  logic [HIST_W-1:0] r_wptr, r_scan;
  logic [HIST_W:0]   r_count;
  logic              r_resp_valid;
  status_t           r_status;
  logic [BAL_W-1:0]  r_bal_out;

  logic              w_resp, w_bal_upd, w_bal_wr, w_hist_wr, w_hist_type, w_pin_wr;
  status_t           w_status;
  logic [BAL_W-1:0]  w_bal_cur, w_bal_new;
  logic [BAL_W:0]    w_amt_ext, w_dep_sum, w_wd_sum;
  logic [ATT_W:0]    w_att_inc;
  logic [HIST_W-1:0] w_slot;
  logic              w_scan_last, w_populated;

  assign w_bal_cur   = r_bal[r_acct];
  assign w_amt_ext   = (BAL_W+1)'(amount);
  // Sums carry one extra bit so overflow and limit tests never wrap.
  assign w_dep_sum   = {1'b0, w_bal_cur} + w_amt_ext;
  assign w_wd_sum    = {1'b0, r_wd} + w_amt_ext;
  assign w_att_inc   = {1'b0, r_att} + (ATT_W+1)'(1);
  assign w_scan_last = (r_scan == HIST_W'(HIST_DEPTH - 1));
  assign w_slot      = r_wptr - r_scan - HIST_W'(1);
  assign w_populated = ({1'b0, r_scan} < r_count);

  assign ready       = (r_state == S_IDLE) || (r_state == S_PIN) || (r_state == S_MENU);
  assign locked      = (r_state == S_LOCKED);
  assign resp_valid  = r_resp_valid;
  assign status      = r_status;
  assign balance_out = r_bal_out;
  assign stmt_valid  = (r_state == S_STMT) && w_populated && (r_h_acct[w_slot] == r_acct);
  assign stmt_data   = stmt_valid ? {r_h_type[w_slot], r_h_amt[w_slot]} : '0;
  assign stmt_done   = (r_state == S_STMT) && w_scan_last;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_acct      = r_acct;
    w_att       = r_att;
    w_tmr       = r_tmr;
    w_wd        = r_wd;
    w_resp      = 1'b0;
    w_status    = ST_OK;
    w_bal_upd   = 1'b0;
    w_bal_wr    = 1'b0;
    w_bal_new   = w_bal_cur;
    w_hist_wr   = 1'b0;
    w_hist_type = 1'b0;
    w_pin_wr    = 1'b0;
    unique case (r_state)
      S_IDLE: if (card_valid) begin
        w_acct = card_id;
        w_att  = '0;
        w_wd   = '0;
        w_next = S_PIN;
      end
      S_PIN: if (pin_valid) begin
        w_resp = 1'b1;
        if (pin_in == r_pin[r_acct]) begin
          w_bal_upd = 1'b1;
          w_att     = '0;
          w_next    = S_MENU;
        end else if (w_att_inc >= (ATT_W+1)'(MAX_ATTEMPTS)) begin
          w_status = ST_LOCKED;
          w_att    = '0;
          w_tmr    = TMR_W'(LOCK_CYCLES);
          w_next   = S_LOCKED;
        end else begin
          w_status = ST_BAD_PIN;
          w_att    = w_att_inc[ATT_W-1:0];
        end
      end
      S_LOCKED: begin
        if (r_tmr <= TMR_W'(1)) begin
          w_tmr  = '0;
          w_next = S_IDLE;
        end else begin
          w_tmr = r_tmr - TMR_W'(1);
        end
      end
      S_MENU: if (op_valid) begin
        w_resp = 1'b1;
        case (op_code)
          3'd0: begin
            if (amount == '0)                      w_status = ST_BAD_OP;
            else if (w_amt_ext > {1'b0, w_bal_cur}) w_status = ST_NO_FUNDS;
            else if (w_wd_sum > (BAL_W+1)'(WD_LIMIT)) w_status = ST_LIMIT;
            else begin
              w_bal_new = w_bal_cur - w_amt_ext[BAL_W-1:0];
              w_bal_wr  = 1'b1;
              w_bal_upd = 1'b1;
              w_wd      = w_wd_sum[BAL_W-1:0];
              w_hist_wr = 1'b1;
            end
          end
          3'd1: begin
            if (amount == '0)        w_status = ST_BAD_OP;
            else if (w_dep_sum[BAL_W]) w_status = ST_OVERFLOW;
            else begin
              w_bal_new   = w_dep_sum[BAL_W-1:0];
              w_bal_wr    = 1'b1;
              w_bal_upd   = 1'b1;
              w_hist_wr   = 1'b1;
              w_hist_type = 1'b1;
            end
          end
          3'd2: w_bal_upd = 1'b1;
          3'd3: begin
            w_resp = 1'b0;
            w_next = S_STMT;
          end
          3'd4: begin
            w_bal_upd = 1'b1;
            w_next    = S_IDLE;
          end
          3'd5: begin
            w_pin_wr  = 1'b1;
            w_bal_upd = 1'b1;
          end
          default: w_status = ST_BAD_OP;
        endcase
      end
      S_STMT: if (w_scan_last) w_next = S_MENU;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acct       <= '0;
      r_att        <= '0;
      r_tmr        <= '0;
      r_wd         <= '0;
      r_bal        <= '{default: BAL_W'(INIT_BALANCE)};
      r_pin        <= '{default: PIN_W'(DEFAULT_PIN)};
      r_h_acct     <= '{default: '0};
      r_h_type     <= '{default: 1'b0};
      r_h_amt      <= '{default: '0};
      r_wptr       <= '0;
      r_scan       <= '0;
      r_count      <= '0;
      r_resp_valid <= 1'b0;
      r_status     <= ST_OK;
      r_bal_out    <= '0;
    end else begin
      r_acct       <= w_acct;
      r_att        <= w_att;
      r_tmr        <= w_tmr;
      r_wd         <= w_wd;
      r_resp_valid <= w_resp;
      r_status     <= w_status;
      if (w_bal_upd) r_bal_out <= w_bal_new;
      if (w_bal_wr)  r_bal[r_acct] <= w_bal_new;
      if (w_pin_wr)  r_pin[r_acct] <= amount[PIN_W-1:0];
      if (w_hist_wr) begin
        r_h_acct[r_wptr] <= r_acct;
        r_h_type[r_wptr] <= w_hist_type;
        r_h_amt[r_wptr]  <= amount;
        r_wptr           <= r_wptr + HIST_W'(1);
        if (r_count != (HIST_W+1)'(HIST_DEPTH)) r_count <= r_count + (HIST_W+1)'(1);
      end
      r_scan <= (r_state == S_STMT) ? r_scan + HIST_W'(1) : '0;
    end
  end
endmodule

// File: tb/tb_atm_session_controller.sv
// Randomised and directed bench for atm_session_controller against a transaction-level
// model (session flags, per-account arrays, newest-first history queue).
module tb_atm_session_controller;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        card_valid = 1'b0;
  logic [1:0]  card_id = '0;
  logic        pin_valid = 1'b0;
  logic [3:0]  pin_in = '0;
  logic        op_valid = 1'b0;
  logic [2:0]  op_code = '0;
  logic [7:0]  amount = '0;
  logic        ready, resp_valid, locked, stmt_valid, stmt_done;
  logic [2:0]  status;
  logic [15:0] balance_out;
  logic [8:0]  stmt_data;

  atm_session_controller #(.NUM_ACCOUNTS(4), .BAL_W(16), .AMT_W(8), .PIN_W(4),
    .DEFAULT_PIN(4), .INIT_BALANCE(128), .MAX_ATTEMPTS(3), .LOCK_CYCLES(24),
    .WD_LIMIT(100), .HIST_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .card_valid(card_valid), .card_id(card_id),
    .pin_valid(pin_valid), .pin_in(pin_in), .op_valid(op_valid), .op_code(op_code),
    .amount(amount), .ready(ready), .resp_valid(resp_valid), .status(status),
    .balance_out(balance_out), .locked(locked), .stmt_valid(stmt_valid),
    .stmt_data(stmt_data), .stmt_done(stmt_done));

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Behavioural model
  typedef struct { int acct; int typ; int amt; } hent_t;
  hent_t hq[$];
  int m_bal[4];
  int m_pin[4];
  bit m_carded, m_auth;
  int m_acct, m_att, m_wd, lock_left, stmt_left;
  bit e_resp;
  int e_status, e_bal_out;

  task automatic model_reset();
    foreach (m_bal[i]) begin m_bal[i] = 128; m_pin[i] = 4; end
    hq.delete();
    m_carded = 0; m_auth = 0; m_acct = 0; m_att = 0; m_wd = 0;
    lock_left = 0; stmt_left = 0; e_resp = 0; e_status = 0; e_bal_out = 0;
  endtask

  task automatic hist_add(input int typ, input int amt);
    hent_t h;
    h.acct = m_acct; h.typ = typ; h.amt = amt;
    hq.push_front(h);
    if (hq.size() > 8) void'(hq.pop_back());
  endtask

  task automatic model_step();
    int a;
    a = int'(amount);
    e_resp = 0;
    if (lock_left > 0) lock_left--;
    else if (stmt_left > 0) stmt_left--;
    else if (!m_carded) begin
      if (card_valid) begin m_carded = 1; m_acct = int'(card_id); m_att = 0; m_wd = 0; end
    end else if (!m_auth) begin
      if (pin_valid) begin
        e_resp = 1;
        if (int'(pin_in) == m_pin[m_acct]) begin
          e_status = 0; m_auth = 1; m_att = 0; e_bal_out = m_bal[m_acct];
        end else if (m_att + 1 >= 3) begin
          e_status = 5; lock_left = 24; m_carded = 0; m_att = 0;
        end else begin
          m_att++; e_status = 1;
        end
      end
    end else if (op_valid) begin
      e_resp = 1; e_status = 0;
      case (int'(op_code))
        0: if (a == 0) e_status = 6;
           else if (a > m_bal[m_acct]) e_status = 2;
           else if (m_wd + a > 100) e_status = 3;
           else begin m_bal[m_acct] -= a; m_wd += a; hist_add(0, a); e_bal_out = m_bal[m_acct]; end
        1: if (a == 0) e_status = 6;
           else if (m_bal[m_acct] + a >= 65536) e_status = 4;
           else begin m_bal[m_acct] += a; hist_add(1, a); e_bal_out = m_bal[m_acct]; end
        2: e_bal_out = m_bal[m_acct];
        3: begin e_resp = 0; stmt_left = 8; end
        4: begin e_bal_out = m_bal[m_acct]; m_carded = 0; m_auth = 0; end
        5: begin m_pin[m_acct] = a % 16; e_bal_out = m_bal[m_acct]; end
        default: e_status = 6;
      endcase
    end
  endtask

  always @(posedge clk) begin
    if (!reset) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int k;
      bit ev;
      check("ready", ready, (lock_left == 0 && stmt_left == 0));
      check("locked", locked, (lock_left > 0));
      check("resp_valid", resp_valid, e_resp);
      if (e_resp) check("status", status, e_status);
      check("balance_out", balance_out, e_bal_out);
      if (stmt_left > 0) begin
        k = 8 - stmt_left;
        ev = (k < hq.size()) && (hq[k].acct == m_acct);
        check("stmt_valid", stmt_valid, ev);
        if (ev) check("stmt_data", stmt_data, hq[k].typ * 256 + hq[k].amt);
        check("stmt_done", stmt_done, (stmt_left == 1));
      end else begin
        check("stmt_valid_idle", stmt_valid, 0);
        check("stmt_done_idle", stmt_done, 0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_card(input int id);
    card_valid = 1'b1; card_id = 2'(id); cyc(); card_valid = 1'b0;
  endtask

  task automatic send_pin(input int p);
    pin_valid = 1'b1; pin_in = 4'(p); cyc(); pin_valid = 1'b0;
  endtask

  task automatic send_op(input int code, input int amt);
    op_valid = 1'b1; op_code = 3'(code); amount = 8'(amt); cyc(); op_valid = 1'b0;
  endtask

  initial begin
    int cnt, r;
    repeat (3) cyc();
    chk_en = 1'b1;
    reset = 1'b1;
    check("lit_reset_ready", ready, 1);
    check("lit_reset_resp", resp_valid, 0);
    check("lit_reset_bal", balance_out, 0);

    // Basic session
    send_card(2); send_pin(4);
    check("lit_pin_ok_valid", resp_valid, 1);
    check("lit_pin_ok", status, 0);
    send_op(0, 30); check("lit_wd30", balance_out, 98);
    send_op(1, 10); check("lit_dep10", balance_out, 108);
    send_op(4, 0);

    // Lockout
    send_card(1);
    send_pin(1); check("lit_bad1", status, 1);
    send_pin(2); check("lit_bad2", status, 1);
    send_pin(3); check("lit_lock_status", status, 5);
    check("lit_locked", locked, 1);
    op_valid = 1'b1; op_code = 3'd2; pin_valid = 1'b1;
    repeat (23) begin cyc(); check("lit_lock_noresp", resp_valid, 0); end
    op_valid = 1'b0; pin_valid = 1'b0;
    check("lit_still_locked", locked, 1);
    cyc();
    check("lit_unlocked", locked, 0);
    check("lit_unlocked_ready", ready, 1);

    // Withdrawal checks
    send_card(0); send_pin(4);
    send_op(0, 60); check("lit_wd60", status, 0); check("lit_wd60_bal", balance_out, 68);
    send_op(0, 50); check("lit_limit", status, 3); check("lit_limit_bal", balance_out, 68);
    send_op(0, 200); check("lit_nofunds", status, 2);
    send_op(0, 0); check("lit_zero", status, 6);
    send_op(4, 0);

    // Overflow boundary
    send_card(3); send_pin(4);
    repeat (256) send_op(1, 255);
    send_op(1, 92); check("lit_65500", balance_out, 65500);
    send_op(1, 100); check("lit_ovf", status, 4); check("lit_ovf_bal", balance_out, 65500);
    send_op(1, 35); check("lit_max_ok", status, 0); check("lit_65535", balance_out, 65535);
    send_op(1, 1); check("lit_ovf1", status, 4);
    send_op(4, 0);

    // Alternating-account history then statement for account 0
    for (int i = 0; i < 10; i++) begin
      send_card(i % 2); send_pin(4);
      if (i % 4 < 2) send_op(1, $urandom_range(1, 50));
      else send_op(0, $urandom_range(1, 15));
      send_op(4, 0);
    end
    send_card(0); send_pin(4); send_op(3, 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (stmt_valid) cnt++;
      if (i == 0) check("lit_stmt_done_early", stmt_done, 0);
      if (i == 7) check("lit_stmt_done", stmt_done, 1);
      cyc();
    end
    check("lit_stmt_count", cnt, 4);
    check("lit_stmt_back_ready", ready, 1);
    send_op(4, 0);

    // PIN change, then reset mid-statement
    send_card(2); send_pin(4);
    send_op(5, 9); check("lit_chpin", status, 0);
    send_op(4, 0);
    send_card(2);
    send_pin(4); check("lit_oldpin", status, 1);
    send_pin(9); check("lit_newpin", status, 0);
    send_op(3, 0);
    repeat (3) cyc();
    reset = 1'b0; cyc(); reset = 1'b1;
    check("lit_rst_ready", ready, 1);
    check("lit_rst_stmt", stmt_valid, 0);
    check("lit_rst_bal_out", balance_out, 0);
    send_card(2); send_pin(4);
    check("lit_rst_pin", status, 0);
    check("lit_rst_balance", balance_out, 128);
    send_op(4, 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      card_valid = ($urandom_range(0, 3) == 0);
      card_id    = 2'($urandom_range(0, 3));
      pin_valid  = ($urandom_range(0, 2) == 0);
      pin_in     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'(m_pin[m_acct]);
      op_valid   = ($urandom_range(0, 1) == 0);
      r = $urandom_range(0, 11);
      op_code    = (r < 4) ? 3'd0 : (r < 7) ? 3'd1 : (r < 8) ? 3'd2 : (r < 9) ? 3'd3 :
                   (r < 10) ? 3'd4 : (r < 11) ? 3'd5 : 3'($urandom_range(6, 7));
      amount     = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
      reset      = ($urandom_range(0, 499) != 0);
      cyc();
    end
    card_valid = 1'b0; pin_valid = 1'b0; op_valid = 1'b0; reset = 1'b1;
    repeat (30) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
